// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Brief    : Shared state encoding and width-derivation helpers for the
//            streaming NxN matrix multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  // Top-level controller states; the fourth code of the 2-bit encoding is
  // never entered and falls back to LOAD.
  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Accumulator width large enough that N full-scale products never overflow.
  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + clog2(n);
  endfunction

  // Number of bytes needed to carry one accumulator value on the byte stream.
  function automatic int res_bytes(input int acc_w);
    return (acc_w + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module   : matmul_mac
// Brief    : DATA_W x DATA_W multiply with ACC_W accumulate. clr_i restarts
//            the sum (combined with en_i it loads the first product).
// Revision : 1.0 - initial release
// ============================================================================
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Operands are widened to the accumulator width before multiplying, so the
  // low ACC_W bits of the product are exact for both number formats.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a_ext = {{(ACC_W - DATA_W){a_i[DATA_W-1]}}, a_i};
      assign w_b_ext = {{(ACC_W - DATA_W){b_i[DATA_W-1]}}, b_i};
    end else begin : g_unsigned
      assign w_a_ext = {{(ACC_W - DATA_W){1'b0}}, a_i};
      assign w_b_ext = {{(ACC_W - DATA_W){1'b0}}, b_i};
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;

  // Next accumulator value: clear-and-load, accumulate, clear, or hold.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = (clr_i ? '0 : acc_q) + w_prod;
    end else if (clr_i) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/matmul_stream_nxn.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_nxn
// Brief    : Byte-streamed NxN matrix multiplier. Loads A then B (row-major,
//            little-endian elements), computes C = A*B one element at a time
//            with a single MAC, and streams each result little-endian.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_stream_nxn
  import matmul_pkg::*;
#(
  parameter int N              = 2,
  parameter int DATA_W         = 8,
  parameter int SIGNED         = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       err_timeout_o,
  output logic       frame_done_o
);

  localparam int EL_BYTES    = DATA_W / 8;
  localparam int ACC_W       = acc_width(N, DATA_W);
  localparam int RES_BYTES   = res_bytes(ACC_W);
  localparam int RES_W       = 8 * RES_BYTES;
  localparam int MAT_BYTES   = N * N * EL_BYTES;
  localparam int FRAME_BYTES = 2 * MAT_BYTES;
  localparam int CNT_W       = clog2(FRAME_BYTES);
  localparam int IDX_W       = clog2(N);
  localparam int RB_W        = clog2(RES_BYTES);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   i_d;
  logic [IDX_W-1:0]   j_q;
  logic [IDX_W-1:0]   j_d;
  logic [IDX_W-1:0]   k_q;
  logic [IDX_W-1:0]   k_d;
  logic [RB_W-1:0]    rb_q;
  logic [RB_W-1:0]    rb_d;
  logic [31:0]        idle_q;
  logic [31:0]        idle_d;
  logic               err_q;
  logic               err_d;
  logic               done_q;
  logic               done_d;
  logic [7:0]         mem_q [FRAME_BYTES];

  logic               w_wr_en;
  logic               w_mac_en;
  logic               w_mac_clr;
  logic               w_in_ready;
  logic               w_out_valid;
  int                 w_a_base;
  int                 w_b_base;
  logic [DATA_W-1:0]  w_a_el;
  logic [DATA_W-1:0]  w_b_el;
  logic [ACC_W-1:0]   w_acc;
  logic [RES_W-1:0]   w_res_ext;
  logic [7:0]         w_out_byte;

  // Controller: next state, counters and per-state outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    rb_d        = rb_q;
    idle_d      = idle_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    w_wr_en     = 1'b0;
    w_mac_en    = 1'b0;
    w_mac_clr   = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (state_q)
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid_i) begin
          w_wr_en = 1'b1;
          idle_d  = 32'd0;
          if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != '0)) begin
          // Idle cycles are only counted once a frame has started.
          if (idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
            cnt_d  = '0;
            idle_d = 32'd0;
            err_d  = 1'b1;
          end else begin
            idle_d = idle_q + 32'd1;
          end
        end
      end
      ST_COMPUTE: begin
        w_mac_en  = 1'b1;
        w_mac_clr = (k_q == '0);
        if (k_q == IDX_W'(N - 1)) begin
          k_d     = '0;
          rb_d    = '0;
          state_d = ST_SEND;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_SEND: begin
        w_out_valid = 1'b1;
        if (out_ready_i) begin
          if (rb_q == RB_W'(RES_BYTES - 1)) begin
            rb_d = '0;
            if (j_q == IDX_W'(N - 1)) begin
              j_d = '0;
              if (i_q == IDX_W'(N - 1)) begin
                i_d     = '0;
                done_d  = 1'b1;
                state_d = ST_LOAD;
              end else begin
                i_d     = i_q + 1'b1;
                state_d = ST_COMPUTE;
              end
            end else begin
              j_d     = j_q + 1'b1;
              state_d = ST_COMPUTE;
            end
          end else begin
            rb_d = rb_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      rb_q    <= '0;
      idle_q  <= 32'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rb_q    <= rb_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Frame byte storage; contents are don't-care until rewritten by a frame.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[cnt_q] <= in_data_i;
    end
  end

  // Operand fetch: A[i][k] and B[k][j] assembled little-endian from storage.
  always_comb begin
    w_a_base = (int'(i_q) * N + int'(k_q)) * EL_BYTES;
    w_b_base = MAT_BYTES + (int'(k_q) * N + int'(j_q)) * EL_BYTES;
    w_a_el   = '0;
    w_b_el   = '0;
    for (int b = 0; b < EL_BYTES; b++) begin
      w_a_el[8*b +: 8] = mem_q[CNT_W'(w_a_base + b)];
      w_b_el[8*b +: 8] = mem_q[CNT_W'(w_b_base + b)];
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_mac_clr),
    .en_i  (w_mac_en),
    .a_i   (w_a_el),
    .b_i   (w_b_el),
    .acc_o (w_acc)
  );

  // Widen the result to a whole number of bytes in its own number format.
  always_comb begin
    if (SIGNED != 0) begin
      w_res_ext = {{(RES_W - ACC_W){w_acc[ACC_W-1]}}, w_acc};
    end else begin
      w_res_ext = {{(RES_W - ACC_W){1'b0}}, w_acc};
    end
  end

  // The accumulator and byte index hold during a stall, so the byte is stable.
  assign w_out_byte    = 8'(w_res_ext >> {rb_q, 3'b000});

  assign in_ready_o    = w_in_ready;
  assign out_valid_o   = w_out_valid;
  assign out_data_o    = w_out_valid ? w_out_byte : 8'h00;
  assign busy_o        = (state_q != ST_LOAD);
  assign err_timeout_o = err_q;
  assign frame_done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_stream_nxn
// Brief    : Self-checking bench. An unsigned and a signed instance receive
//            the same byte stream; each is scored against its own expected
//            result bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_stream_nxn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;

  logic       u_in_ready, u_out_valid, u_busy, u_err, u_done;
  logic [7:0] u_out_data;
  logic       s_in_ready, s_out_valid, s_busy, s_err, s_done;
  logic [7:0] s_out_data;

  int checks = 0;
  int failures = 0;
  int u_done_cnt = 0;
  int s_done_cnt = 0;
  int u_err_cnt = 0;
  int s_err_cnt = 0;

  logic [7:0] exp_u[$];
  logic [7:0] exp_s[$];
  bit         u_prev_stall = 1'b0;
  logic [7:0] u_prev_data = 8'h00;

  typedef struct {
    logic [7:0]  a  [4];
    logic [7:0]  b  [4];
    logic [23:0] eu [4];
    logic [23:0] es [4];
  } vec_t;

  vec_t        tbl [4];
  logic [7:0]  ra  [4];
  logic [7:0]  rbm [4];
  logic [23:0] reu [4];
  logic [23:0] res [4];

  always #5 clk = ~clk;

  matmul_stream_nxn #(.N(2), .DATA_W(8), .SIGNED(0), .TIMEOUT_CYCLES(16)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(u_in_ready), .out_valid_o(u_out_valid), .out_data_o(u_out_data),
    .out_ready_i(out_ready), .busy_o(u_busy), .err_timeout_o(u_err),
    .frame_done_o(u_done)
  );

  matmul_stream_nxn #(.N(2), .DATA_W(8), .SIGNED(1), .TIMEOUT_CYCLES(16)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(s_in_ready), .out_valid_o(s_out_valid), .out_data_o(s_out_data),
    .out_ready_i(out_ready), .busy_o(s_busy), .err_timeout_o(s_err),
    .frame_done_o(s_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference C[i][j] for a 2x2 product, widened to 24 bits.
  function automatic logic [23:0] model(input logic [7:0] a [4], input logic [7:0] b [4],
                                        input int i, input int j, input bit sgn);
    int sum;
    sum = 0;
    for (int k = 0; k < 2; k++) begin
      if (sgn) sum += int'($signed(a[i*2+k])) * int'($signed(b[k*2+j]));
      else     sum += int'(a[i*2+k]) * int'(b[k*2+j]);
    end
    return 24'(sum);
  endfunction

  // Unsigned-instance monitor: scoreboard bytes, stall stability, pulse counts.
  always @(negedge clk) begin
    if (rst) begin
      u_prev_stall = 1'b0;
    end else begin
      if (u_prev_stall) begin
        check("u_stall_valid_hold", u_out_valid, 1);
        check("u_stall_data_hold", u_out_data, u_prev_data);
      end
      u_prev_stall = u_out_valid && !out_ready;
      u_prev_data  = u_out_data;
      if (u_out_valid && out_ready) begin
        if (exp_u.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL u_unexpected_byte actual=%0h expected=none", u_out_data);
        end else begin
          check("u_out_byte", u_out_data, exp_u.pop_front());
        end
      end
      if (u_done) u_done_cnt++;
      if (u_err)  u_err_cnt++;
    end
  end

  // Signed-instance monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_out_valid && out_ready) begin
        if (exp_s.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL s_unexpected_byte actual=%0h expected=none", s_out_data);
        end else begin
          check("s_out_byte", s_out_data, exp_s.pop_front());
        end
      end
      if (s_done) s_done_cnt++;
      if (s_err)  s_err_cnt++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Drive one frame, optionally with an input gap after byte 5 and an output
  // stall on result byte 1, then wait for the frame to finish.
  task automatic run_frame(input logic [7:0] a [4], input logic [7:0] b [4],
                           input logic [23:0] eu [4], input logic [23:0] es [4],
                           input int gap, input bit stall);
    int lat;
    int guard;
    int ud0;
    int sd0;
    logic [7:0] held;
    ud0 = u_done_cnt;
    sd0 = s_done_cnt;
    for (int e = 0; e < 4; e++) begin
      for (int bb = 0; bb < 3; bb++) begin
        exp_u.push_back(eu[e][8*bb +: 8]);
        exp_s.push_back(es[e][8*bb +: 8]);
      end
    end
    for (int n = 0; n < 8; n++) begin
      send_byte(n < 4 ? a[n] : b[n-4]);
      if (n == 4 && gap > 0) wait_cycles(gap);
    end
    // Junk offered while computing must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    check("in_ready_in_compute", u_in_ready, 0);
    check("busy_in_compute", u_busy, 1);
    lat = 1;
    while (!u_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("first_out_latency", lat, 3);
    if (stall) begin
      wait_cycles(1);
      out_ready = 1'b0;
      held = u_out_data;
      wait_cycles(20);
      check("stall_data_after_20", u_out_data, held);
      check("stall_valid_after_20", u_out_valid, 1);
      out_ready = 1'b1;
    end
    guard = 0;
    while (u_done_cnt == ud0 && guard < 300) begin
      wait_cycles(1);
      guard++;
    end
    wait_cycles(4);
    check("u_frame_done_count", u_done_cnt - ud0, 1);
    check("s_frame_done_count", s_done_cnt - sd0, 1);
    check("u_bytes_outstanding", exp_u.size(), 0);
    check("s_bytes_outstanding", exp_s.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int ud0;
    int guard;

    tbl[0].a  = '{8'h01, 8'h02, 8'h03, 8'h04};
    tbl[0].b  = '{8'h05, 8'h06, 8'h07, 8'h08};
    tbl[0].eu = '{24'h000013, 24'h000016, 24'h00002B, 24'h000032};
    tbl[0].es = '{24'h000013, 24'h000016, 24'h00002B, 24'h000032};
    tbl[1].a  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[1].b  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[1].eu = '{24'h01FC02, 24'h01FC02, 24'h01FC02, 24'h01FC02};
    tbl[1].es = '{24'h000002, 24'h000002, 24'h000002, 24'h000002};
    tbl[2].a  = '{8'hFF, 8'h00, 8'h00, 8'h01};
    tbl[2].b  = '{8'h03, 8'h00, 8'h00, 8'h03};
    tbl[2].eu = '{24'h0002FD, 24'h000000, 24'h000000, 24'h000003};
    tbl[2].es = '{24'hFFFFFD, 24'h000000, 24'h000000, 24'h000003};
    tbl[3].a  = '{8'h80, 8'h7F, 8'h01, 8'h00};
    tbl[3].b  = '{8'h80, 8'h01, 8'h7F, 8'h02};
    tbl[3].eu = '{24'h007F01, 24'h00017E, 24'h000080, 24'h000001};
    tbl[3].es = '{24'h007F01, 24'h00007E, 24'hFFFF80, 24'h000001};

    // Reset values.
    rst = 1'b1;
    wait_cycles(3);
    check("rst_in_ready", u_in_ready, 1);
    check("rst_out_valid", u_out_valid, 0);
    check("rst_out_data", u_out_data, 0);
    check("rst_busy", u_busy, 0);
    check("rst_err_timeout", u_err, 0);
    check("rst_frame_done", u_done, 0);
    check("rst_s_out_valid", s_out_valid, 0);
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      run_frame(tbl[v].a, tbl[v].b, tbl[v].eu, tbl[v].es, 0, 1'b0);
    end

    // Random frames against the arithmetic model.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 4; n++) begin
        ra[n]  = 8'($urandom_range(0, 255));
        rbm[n] = 8'($urandom_range(0, 255));
      end
      for (int e = 0; e < 4; e++) begin
        reu[e] = model(ra, rbm, e / 2, e % 2, 1'b0);
        res[e] = model(ra, rbm, e / 2, e % 2, 1'b1);
      end
      run_frame(ra, rbm, reu, res, 0, 1'b0);
    end

    // Output back-pressure on result byte 1.
    run_frame(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es, 0, 1'b1);

    // Partial frame followed by a 16-cycle gap is discarded.
    e0 = u_err_cnt;
    for (int n = 0; n < 5; n++) send_byte(8'(8'h11 * n));
    wait_cycles(15);
    check("no_timeout_before_16", u_err_cnt - e0, 0);
    wait_cycles(3);
    check("u_timeout_pulse", u_err_cnt - e0, 1);
    check("s_timeout_pulse", s_err_cnt - e0, 1);
    check("busy_after_timeout", u_busy, 0);
    check("in_ready_after_timeout", u_in_ready, 1);
    run_frame(tbl[1].a, tbl[1].b, tbl[1].eu, tbl[1].es, 0, 1'b0);

    // A 15-cycle gap inside a frame is tolerated.
    e0 = u_err_cnt;
    run_frame(tbl[2].a, tbl[2].b, tbl[2].eu, tbl[2].es, 15, 1'b0);
    check("no_timeout_gap15", u_err_cnt - e0, 0);

    // Reset in the middle of sending the first result.
    ud0 = u_done_cnt;
    exp_u.push_back(8'h01);
    exp_u.push_back(8'h7F);
    exp_s.push_back(8'h01);
    exp_s.push_back(8'h7F);
    for (int n = 0; n < 8; n++) send_byte(n < 4 ? tbl[3].a[n] : tbl[3].b[n-4]);
    guard = 0;
    while (!u_out_valid && guard < 20) begin
      wait_cycles(1);
      guard++;
    end
    check("rst_test_send_reached", u_out_valid, 1);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    check("midsend_rst_u_out_valid", u_out_valid, 0);
    check("midsend_rst_s_out_valid", s_out_valid, 0);
    check("midsend_rst_busy", u_busy, 0);
    check("midsend_rst_out_data", u_out_data, 0);
    rst = 1'b0;
    wait_cycles(5);
    check("midsend_rst_no_done", u_done_cnt - ud0, 0);
    check("midsend_rst_no_bytes", u_out_valid, 0);
    check("midsend_rst_u_queue", exp_u.size(), 0);
    check("midsend_rst_s_queue", exp_s.size(), 0);
    run_frame(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
